mac_sequencer: RTL and testbench

Control stage directly upstream of `digital_MAC`: on `start`, the sequencer clears the MAC accumulator and streams `num_inputs` activation/weight pairs from two synchronous-read buffers into the MAC, one pair per cycle. It then waits out the MAC latency, captures the 17-bit accumulated dot product, and presents it on a valid/ready output. One sequencer and one `digital_MAC` together compute one neuron or kernel-window output of the CNN layer datapath.

---
 rtl/mac_sequencer.sv | 141 ++++++++++++++
 tb/tb_mac_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// Control sequencer for one digital_MAC: clears the accumulator, streams N
// activation/weight pairs from synchronous-read buffers, then presents the sum.
module mac_sequencer #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned N_W     = 8,
    parameter int unsigned MAC_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [N_W-1:0]    num_inputs,
    input  logic [ADDR_W-1:0] data_base,
    input  logic [ADDR_W-1:0] weight_base,
    output logic              buf_rd,
    output logic [ADDR_W-1:0] data_addr,
    output logic [ADDR_W-1:0] weight_addr,
    input  logic [7:0]        data_q,
    input  logic [7:0]        weight_q,
    output logic              mac_reset,
    output logic              mac_enable,
    output logic [7:0]        mac_data,
    output logic [7:0]        mac_weight,
    input  logic [16:0]       mac_result,
    output logic              busy,
    output logic              out_valid,
    output logic [16:0]       out_result,
    input  logic              out_ready
);

    localparam int unsigned RES_W = 17;
    localparam int unsigned LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        HOLD
    } state_t;

    state_t            state, state_d;
    logic [N_W-1:0]    rem, rem_d;
    logic [LAT_W-1:0]  lat_cnt, lat_cnt_d;
    logic              buf_rd_d;
    logic              mac_reset_d;
    logic              issue;
    logic [ADDR_W-1:0] data_addr_d, weight_addr_d;
    logic [RES_W-1:0]  out_result_d;

    // Next-state and next-output logic; rem counts reads still to be issued.
    always_comb begin
        state_d       = state;
        rem_d         = rem;
        lat_cnt_d     = LAT_W'(MAC_LAT - 1);
        buf_rd_d      = 1'b0;
        data_addr_d   = data_addr;
        weight_addr_d = weight_addr;
        out_result_d  = out_result;
        issue         = ((state == CLEAR) || (state == STREAM)) && (rem != '0);

        if (issue) begin
            buf_rd_d      = 1'b1;
            rem_d         = rem - N_W'(1);
            data_addr_d   = data_addr + ADDR_W'(1);
            weight_addr_d = weight_addr + ADDR_W'(1);
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_d       = CLEAR;
                    buf_rd_d      = (num_inputs != '0);
                    rem_d         = (num_inputs != '0) ? num_inputs - N_W'(1) : '0;
                    data_addr_d   = data_base;
                    weight_addr_d = weight_base;
                end
            end
            CLEAR: begin
                state_d = buf_rd ? STREAM : DRAIN;
            end
            STREAM: begin
                // No read in flight means this cycle carries the final enable.
                if (!buf_rd) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (lat_cnt == '0) begin
                    out_result_d = mac_result;
                    state_d      = HOLD;
                end else begin
                    lat_cnt_d = lat_cnt - LAT_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mac_reset_d = (state_d == CLEAR);
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            rem         <= '0;
            lat_cnt     <= LAT_W'(MAC_LAT - 1);
            buf_rd      <= 1'b0;
            mac_enable  <= 1'b0;
            mac_reset   <= 1'b1;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            data_addr   <= '0;
            weight_addr <= '0;
        end else begin
            state       <= state_d;
            rem         <= rem_d;
            lat_cnt     <= lat_cnt_d;
            buf_rd      <= buf_rd_d;
            mac_enable  <= buf_rd;
            mac_reset   <= mac_reset_d;
            busy        <= (state_d != IDLE);
            out_valid   <= (state_d == HOLD);
            out_result  <= out_result_d;
            data_addr   <= data_addr_d;
            weight_addr <= weight_addr_d;
        end
    end

    // Buffer read data lands the cycle after buf_rd, aligned with mac_enable.
    assign mac_data   = mac_enable ? data_q   : 8'd0;
    assign mac_weight = mac_enable ? weight_q : 8'd0;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer with behavioural buffers and MAC,
// comparing each job against a dot product computed directly from memory.
module tb_mac_sequencer;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned N_W     = 8;
    localparam int unsigned MAC_LAT = 1;
    localparam int unsigned DEPTH   = 1024;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [N_W-1:0]    num_inputs;
    logic [ADDR_W-1:0] data_base;
    logic [ADDR_W-1:0] weight_base;
    logic              buf_rd;
    logic [ADDR_W-1:0] data_addr;
    logic [ADDR_W-1:0] weight_addr;
    logic [7:0]        data_q;
    logic [7:0]        weight_q;
    logic              mac_reset;
    logic              mac_enable;
    logic [7:0]        mac_data;
    logic [7:0]        mac_weight;
    logic [16:0]       mac_result;
    logic              busy;
    logic              out_valid;
    logic [16:0]       out_result;
    logic              out_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0]  dmem [DEPTH];
    logic [7:0]  wmem [DEPTH];
    logic [16:0] acc = 17'd0;

    mac_sequencer #(
        .ADDR_W  (ADDR_W),
        .N_W     (N_W),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .num_inputs  (num_inputs),
        .data_base   (data_base),
        .weight_base (weight_base),
        .buf_rd      (buf_rd),
        .data_addr   (data_addr),
        .weight_addr (weight_addr),
        .data_q      (data_q),
        .weight_q    (weight_q),
        .mac_reset   (mac_reset),
        .mac_enable  (mac_enable),
        .mac_data    (mac_data),
        .mac_weight  (mac_weight),
        .mac_result  (mac_result),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_result  (out_result),
        .out_ready   (out_ready)
    );

    always #5 clock = ~clock;

    // Synchronous-read activation and weight buffers.
    always @(posedge clock) begin
        if (buf_rd) begin
            data_q   <= dmem[data_addr];
            weight_q <= wmem[weight_addr];
        end
    end

    // digital_MAC stand-in: one-cycle accumulate, 17-bit wrap.
    always @(posedge clock) begin
        if (mac_reset)       acc <= 17'd0;
        else if (mac_enable) acc <= acc + 17'(mac_data) * 17'(mac_weight);
    end
    assign mac_result = acc;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < int'(DEPTH); i++) begin
            dmem[i] = 8'($urandom);
            wmem[i] = 8'($urandom);
        end
    endtask

    // One full job: start, stream, observe timing/addresses, backpressure, handshake.
    task automatic run_job(input int n, input int db, input int wb, input int hold, input bit poke);
        int  exp_sum;
        int  cyc;
        int  first_valid;
        int  en_cnt;
        int  en_first;
        int  en_last;
        int  rd_cnt;
        bit  addr_ok;
        bit  stable_ok;

        exp_sum = 0;
        for (int i = 0; i < n; i++) begin
            exp_sum += int'(dmem[(db + i) % DEPTH]) * int'(wmem[(wb + i) % DEPTH]);
        end
        exp_sum = exp_sum % 131072;

        num_inputs  = N_W'(n);
        data_base   = ADDR_W'(db);
        weight_base = ADDR_W'(wb);
        start       = 1'b1;
        tick();
        start       = 1'b0;
        num_inputs  = N_W'($urandom);
        data_base   = ADDR_W'($urandom);
        weight_base = ADDR_W'($urandom);

        cyc = 1; first_valid = -1; en_cnt = 0; en_first = -1; en_last = -1;
        rd_cnt = 0; addr_ok = 1'b1;
        while (cyc <= n + 2 + int'(MAC_LAT) + 8) begin
            if (mac_enable) begin
                en_cnt++;
                if (en_first < 0) en_first = cyc;
                en_last = cyc;
            end
            if (buf_rd) begin
                if (data_addr !== ADDR_W'((db + rd_cnt) % DEPTH) ||
                    weight_addr !== ADDR_W'((wb + rd_cnt) % DEPTH)) addr_ok = 1'b0;
                rd_cnt++;
            end
            if (out_valid) begin
                first_valid = cyc;
                break;
            end
            out_ready = 1'($urandom);
            tick();
            cyc++;
        end
        out_ready = 1'b0;

        check("valid_cycle", first_valid, n + 2 + int'(MAC_LAT));
        if (first_valid < 0) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            return;
        end
        check("enable_count", en_cnt, n);
        check("enable_first", en_first, (n > 0) ? 2 : -1);
        check("enable_last", en_last, (n > 0) ? n + 1 : -1);
        check("read_count", rd_cnt, n);
        check("addr_seq", 32'(addr_ok), 1);
        check("result", 32'(out_result), exp_sum);
        check("busy_hold", 32'(busy), 1);

        stable_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            if (poke && h == 1) start = 1'b1;
            tick();
            start = 1'b0;
            if (out_valid !== 1'b1 || out_result !== 17'(exp_sum) || busy !== 1'b1) stable_ok = 1'b0;
        end
        if (hold > 0) check("hold_stable", 32'(stable_ok), 1);

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_busy", 32'(busy), 0);
        check("idle_valid", 32'(out_valid), 0);
    endtask

    initial begin
        bit quiet;

        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        num_inputs = '0; data_base = '0; weight_base = '0;
        fill_random();
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_buf_rd", 32'(buf_rd), 0);
        check("rst_enable", 32'(mac_enable), 0);
        check("rst_mac_reset", 32'(mac_reset), 1);
        check("rst_result", 32'(out_result), 0);
        check("rst_data_addr", 32'(data_addr), 0);
        check("rst_weight_addr", 32'(weight_addr), 0);
        check("rst_mac_data", 32'(mac_data), 0);
        check("rst_mac_weight", 32'(mac_weight), 0);
        reset = 1'b0;
        tick();

        // Small dot product: 1*4 + 2*5 + 3*6 = 32.
        dmem[0] = 8'd1; dmem[1] = 8'd2; dmem[2] = 8'd3;
        wmem[0] = 8'd4; wmem[1] = 8'd5; wmem[2] = 8'd6;
        run_job(3, 0, 0, 0, 1'b0);
        check("dot32", 32'(out_result), 32);

        // Width limit with backpressure and an ignored start during HOLD.
        dmem[10] = 8'd255; dmem[11] = 8'd255;
        wmem[20] = 8'd255; wmem[21] = 8'd255;
        run_job(2, 10, 20, 5, 1'b1);
        check("width_limit", 32'(out_result), 130050);

        // Address wrap and zero length.
        run_job(4, 1022, int'($urandom_range(0, DEPTH - 1)), 1, 1'b0);
        run_job(0, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)), 0, 1'b0);
        check("zero_len", 32'(out_result), 0);

        // Reset sampled at edge 3 of an N=8 run.
        num_inputs = N_W'(8); data_base = '0; weight_base = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_buf_rd", 32'(buf_rd), 0);
        check("midrst_enable", 32'(mac_enable), 0);
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (mac_enable !== 1'b0 || busy !== 1'b0 || buf_rd !== 1'b0) quiet = 1'b0;
        end
        check("midrst_quiet", 32'(quiet), 1);
        dmem[100] = 8'd7; wmem[200] = 8'd9;
        run_job(1, 100, 200, 2, 1'b1);
        check("after_reset", 32'(out_result), 63);

        // Randomized jobs, including the maximum length.
        for (int j = 0; j < 6; j++) begin
            fill_random();
            run_job(int'($urandom_range(0, 40)), int'($urandom_range(0, DEPTH - 1)),
                    int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 4)), 1'($urandom));
        end
        fill_random();
        run_job(255, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)), 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
